// File: rtl/mode_interval_tally.sv
// Per-mode saturating tally of out-of-interval lane flags, with a valid/ready
// dump port that streams every counter (mode 0 first) on request.
module mode_interval_tally #(
    parameter int LANES       = 4,
    parameter int NUM_MODES   = 8,
    parameter int CNT_W       = 16,
    parameter int CLR_ON_DUMP = 1,
    localparam int MODE_W     = $clog2(NUM_MODES)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [LANES*MODE_W-1:0]   mode_i,
    input  logic [LANES-1:0]          out_of_mode_interval_i,
    input  logic                      clear_i,
    input  logic                      dump_req_i,
    output logic                      dump_valid_o,
    input  logic                      dump_ready_i,
    output logic [MODE_W-1:0]         dump_mode_o,
    output logic [CNT_W-1:0]          dump_cnt_o,
    output logic                      dump_last_o,
    output logic [NUM_MODES-1:0]      sat_o,
    output logic                      busy_o
);

    localparam int INC_W = $clog2(LANES + 1);
    localparam int SUM_W = CNT_W + INC_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DUMP = 1'b1;

    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [SUM_W-1:0]  SUM_MAX   = {{INC_W{1'b0}}, CNT_MAX};

    // Valid/ready: a transfer happens on a rising clock edge where both
    // valid and ready are high; valid, once raised, holds its payload until
    // the transfer (or an abort by clear_i / reset).

    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q [NUM_MODES];
    logic [CNT_W-1:0]     cnt_d [NUM_MODES];
    logic [NUM_MODES-1:0] sat_q, sat_d;
    logic                 dump_valid_q, dump_valid_d;
    logic [MODE_W-1:0]    dump_mode_q, dump_mode_d;
    logic [CNT_W-1:0]     dump_cnt_q, dump_cnt_d;
    logic                 dump_last_q, dump_last_d;

    logic [INC_W-1:0]     inc [NUM_MODES];
    logic                 beat_acc;
    logic [MODE_W-1:0]    mode_nxt;
    logic [SUM_W-1:0]     sum;

    assign ready_o      = (state_q == S_IDLE);
    assign busy_o       = (state_q == S_DUMP);
    assign dump_valid_o = dump_valid_q;
    assign dump_mode_o  = dump_mode_q;
    assign dump_cnt_o   = dump_cnt_q;
    assign dump_last_o  = dump_last_q;
    assign sat_o        = sat_q;

    assign beat_acc = valid_i & ready_o & ~clear_i;
    assign mode_nxt = dump_mode_q + MODE_W'(1);

    // Per-mode count of flagged lanes in the current beat.
    always_comb begin
        for (int m = 0; m < NUM_MODES; m++) begin
            inc[m] = '0;
            for (int l = 0; l < LANES; l++) begin
                if (out_of_mode_interval_i[l] &&
                    (mode_i[l*MODE_W +: MODE_W] == MODE_W'(m))) begin
                    inc[m] = inc[m] + INC_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        dump_valid_d = dump_valid_q;
        dump_mode_d  = dump_mode_q;
        dump_cnt_d   = dump_cnt_q;
        dump_last_d  = dump_last_q;
        sum          = '0;

        if (clear_i) begin
            state_d      = S_IDLE;
            sat_d        = '0;
            dump_valid_d = 1'b0;
            dump_mode_d  = '0;
            dump_cnt_d   = '0;
            dump_last_d  = 1'b0;
            for (int m = 0; m < NUM_MODES; m++) begin
                cnt_d[m] = '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (beat_acc) begin
                        for (int m = 0; m < NUM_MODES; m++) begin
                            sum = {{INC_W{1'b0}}, cnt_q[m]} + {{CNT_W{1'b0}}, inc[m]};
                            if (sum >= SUM_MAX) begin
                                cnt_d[m] = CNT_MAX;
                                sat_d[m] = 1'b1;
                            end else begin
                                cnt_d[m] = sum[CNT_W-1:0];
                            end
                        end
                    end
                    // The first beat shows counter 0 including this cycle's update.
                    if (dump_req_i) begin
                        state_d      = S_DUMP;
                        dump_valid_d = 1'b1;
                        dump_mode_d  = '0;
                        dump_cnt_d   = cnt_d[0];
                        dump_last_d  = (NUM_MODES == 1);
                    end
                end
                S_DUMP: begin
                    if (dump_ready_i) begin
                        if (CLR_ON_DUMP != 0) begin
                            cnt_d[dump_mode_q] = '0;
                            sat_d[dump_mode_q] = 1'b0;
                        end
                        if (dump_last_q) begin
                            state_d      = S_IDLE;
                            dump_valid_d = 1'b0;
                            dump_mode_d  = '0;
                            dump_last_d  = 1'b0;
                        end else begin
                            dump_mode_d = mode_nxt;
                            dump_cnt_d  = cnt_q[mode_nxt];
                            dump_last_d = (mode_nxt == LAST_MODE);
                        end
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    dump_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            sat_q        <= '0;
            dump_valid_q <= 1'b0;
            dump_mode_q  <= '0;
            dump_cnt_q   <= '0;
            dump_last_q  <= 1'b0;
            for (int m = 0; m < NUM_MODES; m++) begin
                cnt_q[m] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sat_q        <= sat_d;
            dump_valid_q <= dump_valid_d;
            dump_mode_q  <= dump_mode_d;
            dump_cnt_q   <= dump_cnt_d;
            dump_last_q  <= dump_last_d;
            for (int m = 0; m < NUM_MODES; m++) begin
                cnt_q[m] <= cnt_d[m];
            end
        end
    end

endmodule

// File: doc/mode_interval_tally.md
Name: mode_interval_tally

Overview:
- Consumer side of the score/interval check stage.
- Takes per-lane out-of-mode-interval flags plus each lane's 3-bit mode, and keeps one saturating event counter per mode.
- On request, streams the counters out over a valid/ready dump port for the host/statistics path.
- Sits directly after the interval-compare pipe stage in the score pipeline.

Parameters:
LANES, 4, parallel score lanes per beat
NUM_MODES, 8, number of modes / counters (mode index width MODE_W = $clog2(NUM_MODES) = 3)
CNT_W, 16, counter width (matches interval count width para)
CLR_ON_DUMP, 1, 1 = each counter is zeroed when its dump beat handshakes

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  flag beat valid
ready_o  out  1  beat accepted when valid_i&ready_o
mode_i  in  LANES x MODE_W  mode of each lane
out_of_mode_interval_i  in  LANES  1 = lane score fell outside its mode interval
clear_i  in  1  synchronous clear of all counters and sticky bits
dump_req_i  in  1  start a counter dump (level, sampled in IDLE)
dump_valid_o  out  1  dump beat valid
dump_ready_i  in  1  downstream accepts dump beat
dump_mode_o  out  MODE_W  mode index of the current dump beat
dump_cnt_o  out  CNT_W  counter value for dump_mode_o
dump_last_o  out  1  high on the beat for mode NUM_MODES-1
sat_o  out  NUM_MODES  sticky: counter m has saturated
busy_o  out  1  high while in DUMP

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE; all counters=0; sat_o=0; dump_valid_o=0; dump_mode_o=0; dump_cnt_o=0; dump_last_o=0; busy_o=0. ready_o=1 as soon as reset deasserts.
- FSM states: IDLE, DUMP.
- IDLE behaviour:
  - ready_o=1.
  - On an accepted beat, for each mode m: inc_m = number of lanes with out_of_mode_interval_i[l]=1 and mode_i[l]==m (0..LANES).
  - cnt[m] <= min(cnt[m]+inc_m, 2^CNT_W-1). Compute the sum at CNT_W+$clog2(LANES+1) bits, then clamp.
  - If the clamp engages or the result equals the maximum, sat_o[m] <= 1 (sticky).
  - Counters update 1 cycle after acceptance; there is no other latency.
- IDLE->DUMP: when dump_req_i=1. A beat accepted in that same cycle is counted and is included in the dump. The next cycle: ready_o=0, busy_o=1, dump_valid_o=1, dump_mode_o=0.
- DUMP behaviour:
  - dump_cnt_o = cnt[dump_mode_o]. dump_mode_o, dump_cnt_o and dump_last_o are held stable while dump_valid_o=1 and dump_ready_i=0.
  - On each handshake: if CLR_ON_DUMP, cnt[dump_mode_o] <= 0 and sat_o[dump_mode_o] <= 0. Then dump_mode_o increments.
  - On the handshake with dump_last_o=1: return to IDLE. dump_valid_o=0 and ready_o=1 in the next cycle.
  - dump_valid_o stays high back-to-back (one beat per cycle when dump_ready_i=1), so a full dump takes NUM_MODES cycles minimum.
  - Flag beats are never accepted in DUMP (ready_o=0), so counters are frozen except for the dump clears.
- clear_i has the highest priority, in either state:
  - Next cycle: all counters=0, sat_o=0, state=IDLE, dump_valid_o=0.
  - A beat presented with clear_i=1 is accepted but discarded (not counted).
  - A dump in progress is aborted without a last beat.
- dump_req_i is ignored while already in DUMP; a held request starts a new dump on the first IDLE cycle after the last beat.
- Lanes with out_of_mode_interval_i=0 never affect counters, whatever their mode_i.
- Dump output values are registered; dump_cnt_o changes only on mode advance or entry to DUMP.

Test Plan:
- Reset then accept one beat with flags=4'b1111, modes={3,3,3,3} -> cnt[3]=4, others 0. A dump then yields beats mode 0..7 with counts {0,0,0,4,0,0,0,0}, dump_last_o on mode 7, sat_o=0.
- Preload cnt[5]=16'hFFFE via beats, then send a beat with modes all 5 and flags 1111 -> cnt[5]=16'hFFFF, sat_o[5]=1. A further beat leaves it 16'hFFFF.
- Dump with dump_ready_i toggling 1,0,0,1,...: each beat is held stable while stalled, with exactly 8 handshakes. With CLR_ON_DUMP=1, a second dump returns all zeros and sat_o=0.
- dump_req_i and valid_i in the same cycle (flags 0001, mode_i[0]=2) -> cnt[2] incremented; the dump's mode-2 beat shows the new value; ready_o=0 for the next 8+ cycles.
- Assert clear_i during dump beat mode 4 -> dump_valid_o=0 the next cycle, all counters 0, ready_o=1, no dump_last_o seen.
- Assert rst_ni low mid-dump, asynchronously -> outputs are zero immediately, without waiting for a clock edge. After release, state is IDLE and a fresh dump reports all zeros.
